// File: rtl/setpoint_keypad.sv
// Front-panel keypad: synchronizes and debounces UP/DN/OK buttons, steps a
// saturating edit setpoint with hold-to-repeat, and commits it to DT on OK.
module setpoint_keypad #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int REP_CYCLES  = 8,
    parameter int T_MIN       = 5,
    parameter int T_MAX       = 30,
    parameter int T_RESET     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTN_UP,
    input  logic       BTN_DN,
    input  logic       BTN_OK,
    output logic [4:0] DT_EDIT,
    output logic [4:0] DT,
    output logic       CONF,
    output logic       DIRTY
);

    localparam int CW      = $clog2(DEB_CYCLES + 1);
    localparam int TLIM    = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
    localparam int TW      = $clog2(TLIM + 1);
    localparam int B_UP    = 0;
    localparam int B_DN    = 1;
    localparam int B_OK    = 2;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, BLOCK} state_t;

    function automatic logic [4:0] sat_step(input logic [4:0] v, input logic up);
        logic [4:0] r;
        if (up) begin
            r = (v >= 5'(T_MAX)) ? 5'(T_MAX) : v + 5'd1;
        end else begin
            r = (v <= 5'(T_MIN)) ? 5'(T_MIN) : v - 5'd1;
        end
        return r;
    endfunction

    logic [2:0]         sync1_q, sync1_d;
    logic [2:0]         sync2_q, sync2_d;
    logic [2:0]         stb_q, stb_d;
    logic [2:0]         prev_q, prev_d;
    logic [2:0][CW-1:0] cnt_q, cnt_d;

    state_t             state_q, state_d;
    logic               dir_q, dir_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [4:0]         edit_q, edit_d;
    logic [4:0]         dt_q, dt_d;
    logic               conf_q, conf_d;

    logic up_lvl, dn_lvl, up_rise, dn_rise, ok_rise, act_lvl, opp_lvl;

    // Input conditioning: two-flop synchronizer then a per-button stability counter
    always_comb begin
        sync1_d = {BTN_OK, BTN_DN, BTN_UP};
        sync2_d = sync1_q;
        prev_d  = stb_q;
        stb_d   = stb_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != stb_q[i]) begin
                if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                    stb_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    assign up_lvl  = stb_q[B_UP];
    assign dn_lvl  = stb_q[B_DN];
    assign up_rise = stb_q[B_UP] & ~prev_q[B_UP];
    assign dn_rise = stb_q[B_DN] & ~prev_q[B_DN];
    assign ok_rise = stb_q[B_OK] & ~prev_q[B_OK];
    assign act_lvl = dir_q ? up_lvl : dn_lvl;
    assign opp_lvl = dir_q ? dn_lvl : up_lvl;

    // Step FSM and commit; DT samples the edit register before any same-cycle step
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        edit_d  = edit_q;
        dt_d    = dt_q;
        conf_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (up_lvl && dn_lvl) begin
                    state_d = BLOCK;
                end else if (up_rise) begin
                    edit_d  = sat_step(edit_q, 1'b1);
                    dir_d   = 1'b1;
                    timer_d = '0;
                    state_d = HOLD;
                end else if (dn_rise) begin
                    edit_d  = sat_step(edit_q, 1'b0);
                    dir_d   = 1'b0;
                    timer_d = '0;
                    state_d = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (opp_lvl) begin
                    state_d = BLOCK;
                end else if (!act_lvl) begin
                    state_d = IDLE;
                end else if ((state_q == HOLD   && timer_q == TW'(HOLD_CYCLES - 1)) ||
                             (state_q == REPEAT && timer_q == TW'(REP_CYCLES - 1))) begin
                    edit_d  = sat_step(edit_q, dir_q);
                    timer_d = '0;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            BLOCK: begin
                if (!up_lvl && !dn_lvl) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ok_rise) begin
            dt_d   = edit_q;
            conf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            stb_q   <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            dir_q   <= 1'b0;
            timer_q <= '0;
            edit_q  <= 5'(T_RESET);
            dt_q    <= 5'(T_RESET);
            conf_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            stb_q   <= stb_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            edit_q  <= edit_d;
            dt_q    <= dt_d;
            conf_q  <= conf_d;
        end
    end

    assign DT_EDIT = edit_q;
    assign DT      = dt_q;
    assign CONF    = conf_q;
    assign DIRTY   = (edit_q != dt_q);

endmodule

// File: tb/tb_setpoint_keypad.sv
// Bench for setpoint_keypad: directed scenarios plus randomized presses checked
// against a press-duration model of the keypad.
module tb_setpoint_keypad;

    localparam int DEB  = 4;
    localparam int HOLD = 16;
    localparam int REP  = 8;
    localparam int TMIN = 5;
    localparam int TMAX = 30;
    localparam int TRST = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       BTN_UP = 1'b0;
    logic       BTN_DN = 1'b0;
    logic       BTN_OK = 1'b0;
    logic [4:0] DT_EDIT;
    logic [4:0] DT;
    logic       CONF;
    logic       DIRTY;

    int total = 0;
    int bad   = 0;
    int m_edit = TRST;
    int m_dt   = TRST;

    always #5 clk = ~clk;

    setpoint_keypad #(
        .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REP_CYCLES(REP),
        .T_MIN(TMIN), .T_MAX(TMAX), .T_RESET(TRST)
    ) dut (
        .clk(clk), .rst(rst),
        .BTN_UP(BTN_UP), .BTN_DN(BTN_DN), .BTN_OK(BTN_OK),
        .DT_EDIT(DT_EDIT), .DT(DT), .CONF(CONF), .DIRTY(DIRTY)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // A raw press of n cycles stays debounced-high for n cycles if n >= DEB.
    // Steps fall at offsets 0, HOLD, HOLD+REP, ... below n.
    function automatic int steps_for(input int n);
        if (n < DEB)   return 0;
        if (n <= HOLD) return 1;
        return 2 + (n - HOLD - 1) / REP;
    endfunction

    function automatic int sat_move(input int v, input bit up, input int k);
        int r;
        r = up ? v + k : v - k;
        if (r > TMAX) r = TMAX;
        if (r < TMIN) r = TMIN;
        return r;
    endfunction

    task automatic press(input bit up, input bit dn, input bit ok, input int n);
        BTN_UP = up; BTN_DN = dn; BTN_OK = ok;
        repeat (n) tick;
        BTN_UP = 1'b0; BTN_DN = 1'b0; BTN_OK = 1'b0;
        repeat (DEB + 8) tick;
        if (ok && n >= DEB) m_dt = m_edit;
        if (up != dn) m_edit = sat_move(m_edit, up, steps_for(n));
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick;
        total++; if (DT_EDIT !== 5'(TRST)) begin bad++; $display("FAIL reset_edit: got %0d want %0d", DT_EDIT, TRST); end
        total++; if (DT !== 5'(TRST)) begin bad++; $display("FAIL reset_dt: got %0d want %0d", DT, TRST); end
        total++; if (CONF !== 1'b0) begin bad++; $display("FAIL reset_conf: got %0b want 0", CONF); end
        total++; if (DIRTY !== 1'b0) begin bad++; $display("FAIL reset_dirty: got %0b want 0", DIRTY); end
    endtask

    task automatic test_glitch;
        press(1'b1, 1'b0, 1'b0, 3);
        total++; if (DT_EDIT !== 5'(m_edit)) begin bad++; $display("FAIL glitch_edit: got %0d want %0d", DT_EDIT, m_edit); end
    endtask

    task automatic test_single_step;
        int base;
        base = m_edit;
        BTN_UP = 1'b1;
        repeat (6) tick;
        total++; if (DT_EDIT !== 5'(base)) begin bad++; $display("FAIL step_early: got %0d want %0d", DT_EDIT, base); end
        BTN_UP = 1'b0;
        tick;
        total++; if (DT_EDIT !== 5'(base + 1)) begin bad++; $display("FAIL step_edge7: got %0d want %0d", DT_EDIT, base + 1); end
        total++; if (DIRTY !== 1'b1) begin bad++; $display("FAIL step_dirty: got %0b want 1", DIRTY); end
        repeat (DEB + 8) tick;
        m_edit = base + 1;
        total++; if (DT_EDIT !== 5'(m_edit)) begin bad++; $display("FAIL step_once: got %0d want %0d", DT_EDIT, m_edit); end
    endtask

    task automatic test_auto_repeat(input int n);
        int base, cnt, exp;
        base = m_edit;
        BTN_UP = 1'b1;
        for (int e = 1; e <= n + 12; e++) begin
            if (e == n + 1) BTN_UP = 1'b0;
            tick;
            cnt = 0;
            for (int o = 0; o < n; o = (o == 0) ? HOLD : o + REP)
                if (DEB + 3 + o <= e) cnt++;
            exp = sat_move(base, 1'b1, cnt);
            total++; if (DT_EDIT !== 5'(exp)) begin bad++; $display("FAIL repeat_cycle%0d: got %0d want %0d", e, DT_EDIT, exp); end
        end
        m_edit = sat_move(base, 1'b1, steps_for(n));
        repeat (20) tick;
        total++; if (DT_EDIT !== 5'(m_edit)) begin bad++; $display("FAIL repeat_after_release: got %0d want %0d", DT_EDIT, m_edit); end
    endtask

    task automatic test_async_reset;
        BTN_UP = 1'b1;
        repeat (30) tick;
        m_edit = sat_move(m_edit, 1'b1, 2);
        total++; if (DT_EDIT !== 5'(m_edit)) begin bad++; $display("FAIL pre_reset_edit: got %0d want %0d", DT_EDIT, m_edit); end
        #2 rst = 1'b0;
        #1;
        total++; if (DT_EDIT !== 5'(TRST)) begin bad++; $display("FAIL async_reset_edit: got %0d want %0d", DT_EDIT, TRST); end
        total++; if (DT !== 5'(TRST)) begin bad++; $display("FAIL async_reset_dt: got %0d want %0d", DT, TRST); end
        BTN_UP = 1'b0;
        repeat (2) tick;
        rst = 1'b1;
        repeat (30) tick;
        m_edit = TRST; m_dt = TRST;
        total++; if (DT_EDIT !== 5'(TRST)) begin bad++; $display("FAIL post_reset_nostep: got %0d want %0d", DT_EDIT, TRST); end
    endtask

    task automatic test_saturation;
        press(1'b1, 1'b0, 1'b0, 300);
        total++; if (DT_EDIT !== 5'(m_edit)) begin bad++; $display("FAIL sat_top: got %0d want %0d", DT_EDIT, m_edit); end
        press(1'b0, 1'b1, 1'b0, 6);
        for (int k = 0; k < 3; k++) begin
            press(1'b1, 1'b0, 1'b0, 6);
            total++; if (DT_EDIT !== 5'(m_edit)) begin bad++; $display("FAIL sat_up%0d: got %0d want %0d", k, DT_EDIT, m_edit); end
        end
        press(1'b0, 1'b1, 1'b0, 300);
        press(1'b1, 1'b0, 1'b0, 6);
        for (int k = 0; k < 3; k++) begin
            press(1'b0, 1'b1, 1'b0, 6);
            total++; if (DT_EDIT !== 5'(m_edit)) begin bad++; $display("FAIL sat_dn%0d: got %0d want %0d", k, DT_EDIT, m_edit); end
        end
    endtask

    task automatic test_commit;
        int pulses;
        press(1'b1, 1'b0, 1'b0, 30);
        for (int r = 0; r < 2; r++) begin
            pulses = 0;
            BTN_OK = 1'b1;
            for (int c = 0; c < 50 + DEB + 8; c++) begin
                if (c == 50) BTN_OK = 1'b0;
                tick;
                if (CONF === 1'b1) pulses++;
            end
            m_dt = m_edit;
            total++; if (pulses !== 1) begin bad++; $display("FAIL commit%0d_conf_cycles: got %0d want 1", r, pulses); end
            total++; if (DT !== 5'(m_dt)) begin bad++; $display("FAIL commit%0d_dt: got %0d want %0d", r, DT, m_dt); end
            total++; if (DIRTY !== 1'b0) begin bad++; $display("FAIL commit%0d_dirty: got %0b want 0", r, DIRTY); end
        end
    endtask

    task automatic test_commit_and_step;
        press(1'b1, 1'b0, 1'b1, 6);
        total++; if (DT !== 5'(m_dt)) begin bad++; $display("FAIL same_cycle_dt: got %0d want %0d", DT, m_dt); end
        total++; if (DT_EDIT !== 5'(m_edit)) begin bad++; $display("FAIL same_cycle_edit: got %0d want %0d", DT_EDIT, m_edit); end
        total++; if (DIRTY !== (m_edit != m_dt)) begin bad++; $display("FAIL same_cycle_dirty: got %0b want %0b", DIRTY, m_edit != m_dt); end
    endtask

    task automatic test_block;
        BTN_UP = 1'b1; BTN_DN = 1'b1;
        repeat (40) tick;
        total++; if (DT_EDIT !== 5'(m_edit)) begin bad++; $display("FAIL block_both: got %0d want %0d", DT_EDIT, m_edit); end
        BTN_UP = 1'b0;
        repeat (20) tick;
        total++; if (DT_EDIT !== 5'(m_edit)) begin bad++; $display("FAIL block_dn_only: got %0d want %0d", DT_EDIT, m_edit); end
        BTN_DN = 1'b0;
        repeat (12) tick;
        press(1'b0, 1'b1, 1'b0, 6);
        total++; if (DT_EDIT !== 5'(m_edit)) begin bad++; $display("FAIL block_exit_dn: got %0d want %0d", DT_EDIT, m_edit); end
    endtask

    task automatic test_random;
        int kind, n;
        bit up, dn, ok;
        for (int it = 0; it < 24; it++) begin
            kind = int'($urandom_range(0, 4));
            n    = int'($urandom_range(1, 45));
            up = (kind == 0) || (kind == 3) || (kind == 4);
            dn = (kind == 1) || (kind == 4);
            ok = (kind == 2) || (kind == 3);
            press(up, dn, ok, n);
            total++; if (DT_EDIT !== 5'(m_edit)) begin bad++; $display("FAIL rand%0d_edit k=%0d n=%0d: got %0d want %0d", it, kind, n, DT_EDIT, m_edit); end
            total++; if (DT !== 5'(m_dt)) begin bad++; $display("FAIL rand%0d_dt k=%0d n=%0d: got %0d want %0d", it, kind, n, DT, m_dt); end
            total++; if (DIRTY !== (m_edit != m_dt)) begin bad++; $display("FAIL rand%0d_dirty: got %0b want %0b", it, DIRTY, m_edit != m_dt); end
        end
    endtask

    initial begin
        test_reset;
        test_glitch;
        test_single_step;
        test_auto_repeat(41);
        test_async_reset;
        test_saturation;
        test_commit;
        test_commit_and_step;
        test_block;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/setpoint_keypad.md
Name: setpoint_keypad

Overview:
- Front-panel input stage that sits directly upstream of the thermostat top level.
- Turns raw, bouncing push-buttons into a debounced, auto-repeating desired-temperature setpoint.
- Outputs a committed 5-bit DT value plus a one-cycle CONF strobe, which feed the thermostat's DT and CONF inputs.
- An edit value is also exported for the display.

Parameters:
DEB_CYCLES, 4, consecutive stable synchronized samples required before a button level change is accepted
HOLD_CYCLES, 16, cycles a button must stay held after its first step before auto-repeat starts
REP_CYCLES, 8, cycles between auto-repeat steps
T_MIN, 5, lowest legal setpoint
T_MAX, 30, highest legal setpoint
T_RESET, 8, setpoint loaded at reset (T_MIN <= T_RESET <= T_MAX)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
BTN_UP  in  1  raw increment button, active-high, asynchronous to clk
BTN_DN  in  1  raw decrement button, active-high, asynchronous to clk
BTN_OK  in  1  raw confirm button, active-high, asynchronous to clk
DT_EDIT  out  5  working setpoint being edited
DT  out  5  committed setpoint to thermostat
CONF  out  1  one-cycle pulse when DT is updated
DIRTY  out  1  DT_EDIT != DT

Behaviour:
- Reset (rst=0, asynchronous):
  - DT_EDIT=T_RESET, DT=T_RESET, CONF=0.
  - All synchronizers, debounce counters and FSMs are cleared to the released/IDLE state.
  - Reset asserted mid-repeat or mid-debounce aborts it immediately; no step occurs on release of reset.
- Input conditioning, per button:
  - 2-FF synchronizer.
  - Debouncer holds a stable level and a counter. The counter increments while the synchronized value differs from the stable level, and clears when they match.
  - When the counter reaches DEB_CYCLES, the stable level flips and the counter clears.
  - Any glitch shorter than DEB_CYCLES samples is rejected.
  - Raw-to-debounced latency is DEB_CYCLES+2 rising edges.
- Step FSM (shared by UP and DN): states IDLE, HOLD, REPEAT, BLOCK.
  - IDLE:
    - Debounced UP rise with DN low: apply +1, go to HOLD, timer=0.
    - Debounced DN rise with UP low: apply -1, go to HOLD, timer=0.
    - Both high: go to BLOCK.
  - HOLD: timer counts each cycle. At HOLD_CYCLES, apply the same step again, go to REPEAT, timer=0.
  - REPEAT: at REP_CYCLES, apply step, timer=0, stay in REPEAT.
  - HOLD/REPEAT exits:
    - Active button released: go to IDLE.
    - Opposite button becomes high: go to BLOCK, no step.
  - BLOCK: no steps. Return to IDLE only when both debounced levels are low.
  - A step lands in DT_EDIT one cycle after the triggering debounced edge or timer expiry.
- Arithmetic: saturating.
  - +1 at T_MAX leaves T_MAX; -1 at T_MIN leaves T_MIN.
  - No wrap-around; the FSM and timers keep running while saturated.
- Commit:
  - A debounced BTN_OK rising edge loads DT <= DT_EDIT and pulses CONF=1 for exactly one cycle.
  - Holding OK does not re-commit; a new rising edge is required.
  - A commit with DT_EDIT==DT still pulses CONF.
- Simultaneous OK commit and step in the same cycle: DT captures the pre-step DT_EDIT register value, and DT_EDIT takes the stepped value, so DIRTY=1 afterwards.
- DIRTY is combinational from the two registers.
- DT and DT_EDIT are always within [T_MIN, T_MAX].

Test Plan:
- rst=0 for 2 cycles, then released -> DT=8, DT_EDIT=8, CONF=0, DIRTY=0. Assert rst while DT_EDIT=12 -> DT_EDIT returns to 8 in the same cycle, without waiting for a clock edge.
- BTN_UP high for 3 cycles, then low -> DT_EDIT stays 8. BTN_UP high for 6 cycles -> DT_EDIT=9 exactly once, 7 edges after the raw rise, DIRTY=1.
- BTN_UP held until 40 cycles after its debounced rise -> steps at +0, +16, +24, +32, +40 -> DT_EDIT=13. Release -> FSM returns to IDLE, no further steps.
- From DT_EDIT=29, three separate UP presses -> 30, 30, 30. From 6, three DN presses -> 5, 5, 5. No wrap in either direction.
- DT_EDIT=13, press OK -> DT=13, CONF high for exactly 1 cycle, DIRTY=0. Hold OK for 50 cycles -> no further CONF pulse.
- BTN_UP and BTN_DN rise together and are held 40 cycles -> DT_EDIT unchanged. Release UP only -> still no step (BLOCK). Release both, then press DN -> DT_EDIT decrements by 1.
